// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: access size
// encodings, FSM state encoding and small helpers for strobes, data
// replication, alignment and misalignment detection.
// Optional feature macro: ADDR_EXC_EN (see dmem_access_ctrl.sv).
package dmem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;  // 2'd3 is handled as a word as well

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } state_t;

  // Half accesses need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  // Force the address onto the natural boundary of the access.
  function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      SZ_BYTE: align_addr = addr;
      SZ_HALF: align_addr = {addr[31:1], 1'b0};
      default: align_addr = {addr[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_strobe = 4'b0001 << off;
      SZ_HALF: byte_strobe = 4'b0011 << off;
      default: byte_strobe = 4'b1111;
    endcase
  endfunction

  // Store data is right-aligned on the pipeline side; replicate it across
  // all lanes so the strobes alone pick the bytes that land in memory.
  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: replicate_wdata = {4{wdata[7:0]}};
      SZ_HALF: replicate_wdata = {2{wdata[15:0]}};
      default: replicate_wdata = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus: request/address phase plus data/response phase.
// master = controller side, slave = memory side.
interface dmem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_load_align_ext.sv
// Load result formatting: picks the addressed byte/half lane out of the bus
// word and sign- or zero-extends it to 32 bits. Purely combinational.
module load_align_ext
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  // Lane select followed by extension according to access size.
  always_comb begin
    lane_b = lanes[offset];
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{sign & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage to data-bus sequencer. One load/store in flight at a time;
// stalls the pipeline until the bus responds, returns extended load data,
// and absorbs flushes without abandoning an already-issued bus transaction.
// Optional feature macro: ADDR_EXC_EN -- when defined, misaligned accesses
// raise mem_adel/mem_ades with mem_badvaddr and are not issued; otherwise the
// address is silently aligned before issue.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_allowin,
  input  logic        flush,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr,
  dmem_access_ctrl_if.master bus
);

  state_t      state_reg;
  logic        data_req_reg;
  logic        data_wr_reg;
  logic [1:0]  data_size_reg;
  logic [31:0] data_addr_reg;
  logic [3:0]  data_wstrb_reg;
  logic [31:0] data_wdata_reg;
  logic        sign_reg;
  logic [31:0] mem_rdata_reg;

  logic        addr_error;
  logic [31:0] issue_addr;
  logic        accept;
  logic [31:0] load_data;

`ifdef ADDR_EXC_EN
  logic misalign;
  logic err_cycle;

  assign misalign     = is_misaligned(mem_size, mem_addr[1:0]);
  assign addr_error   = misalign;
  assign issue_addr   = mem_addr;
  // The error pulse is only meaningful while idle; a flushed instruction
  // raises nothing.
  assign err_cycle    = resetn && (state_reg == ST_IDLE) && mem_req && !flush && misalign;
  assign mem_adel     = err_cycle & ~mem_wr;
  assign mem_ades     = err_cycle & mem_wr;
  assign mem_badvaddr = err_cycle ? mem_addr : 32'd0;
`else
  assign addr_error   = 1'b0;
  assign issue_addr   = align_addr(mem_size, mem_addr);
  assign mem_adel     = 1'b0;
  assign mem_ades     = 1'b0;
  assign mem_badvaddr = 32'd0;
`endif

  assign accept = resetn && (state_reg == ST_IDLE) && mem_req && !flush && !addr_error;

  // Stall the acceptance cycle combinationally, then for every state that
  // still owes the bus a response.
  assign mem_stall = accept || (state_reg == ST_REQ) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_CANCEL);

  load_align_ext u_load_align_ext (
    .rdata  (bus.data_rdata),
    .offset (data_addr_reg[1:0]),
    .size   (data_size_reg),
    .sign   (sign_reg),
    .data   (load_data)
  );

  // Sequencer FSM with all bus-facing outputs and the load result registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      data_req_reg   <= 1'b0;
      data_wr_reg    <= 1'b0;
      data_size_reg  <= 2'd0;
      data_addr_reg  <= 32'd0;
      data_wstrb_reg <= 4'd0;
      data_wdata_reg <= 32'd0;
      sign_reg       <= 1'b0;
      mem_rdata_reg  <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg      <= ST_REQ;
            data_req_reg   <= 1'b1;
            data_wr_reg    <= mem_wr;
            data_size_reg  <= mem_size;
            data_addr_reg  <= issue_addr;
            data_wstrb_reg <= mem_wr ? byte_strobe(mem_size, issue_addr[1:0]) : 4'd0;
            data_wdata_reg <= replicate_wdata(mem_size, mem_wdata);
            sign_reg       <= mem_sign;
          end
        end
        ST_REQ: begin
          if (bus.data_addr_ok) begin
            data_req_reg <= 1'b0;
            if (bus.data_data_ok) begin
              if (flush) begin
                state_reg <= ST_IDLE;
              end else begin
                state_reg <= ST_DONE;
                if (!data_wr_reg) mem_rdata_reg <= load_data;
              end
            end else begin
              // Once accepted the bus owes a response, so a flush must wait it out.
              state_reg <= flush ? ST_CANCEL : ST_WAIT;
            end
          end else if (flush) begin
            state_reg    <= ST_IDLE;
            data_req_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.data_data_ok) begin
            if (flush) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_DONE;
              if (!data_wr_reg) mem_rdata_reg <= load_data;
            end
          end else if (flush) begin
            state_reg <= ST_CANCEL;
          end
        end
        ST_CANCEL: begin
          if (bus.data_data_ok) state_reg <= ST_IDLE;
        end
        ST_DONE: begin
          if (mem_allowin || flush) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_req   = data_req_reg;
  assign bus.data_wr    = data_wr_reg;
  assign bus.data_size  = data_size_reg;
  assign bus.data_addr  = data_addr_reg;
  assign bus.data_wstrb = data_wstrb_reg;
  assign bus.data_wdata = data_wdata_reg;
  assign mem_rdata      = mem_rdata_reg;

endmodule
